// File: rtl/cp0_unit.sv
// Coprocessor-0 subset: SR, Cause, EPC, PRId, plus exception/interrupt request
// generation and the entry/return state updates.
module cp0_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] wdata,
   input  logic [31:0] vpc,
   input  logic        bd_in,
   input  logic [4:0]  exc_code_in,
   input  logic [5:0]  hw_int,
   input  logic        exl_clr,
   output logic [31:0] rdata,
   output logic [31:0] epc_out,
   output logic        req
);

   localparam logic [31:0] PRID_VALUE = 32'h2021_0007;

   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc;
   logic        int_req;
   logic        exc_req;

   always_comb begin
      int_req = !sr_exl && sr_ie && (|(hw_int & sr_im));
      exc_req = !sr_exl && (exc_code_in != 5'd0);
      req     = int_req || exc_req;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im     <= '0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= '0;
         cause_exc <= '0;
         epc       <= '0;
      end else begin
         cause_ip <= hw_int;
         if (req) begin
            // exception entry overrides any mtc0 issued in the same cycle
            sr_exl    <= 1'b1;
            cause_bd  <= bd_in;
            cause_exc <= int_req ? 5'd0 : exc_code_in;
            epc       <= bd_in ? (vpc - 32'd4) : vpc;
         end else begin
            if (we) begin
               case (cp0_addr)
                  5'd12: begin
                     sr_im  <= wdata[15:10];
                     sr_exl <= wdata[1];
                     sr_ie  <= wdata[0];
                  end
                  5'd14:   epc <= {wdata[31:2], 2'b00};
                  default: ;
               endcase
            end
            // placed after the SR write so eret always wins on EXL
            if (exl_clr) sr_exl <= 1'b0;
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (cp0_addr)
         5'd12:   rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
         5'd13:   rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
         5'd14:   rdata = epc;
         5'd15:   rdata = PRID_VALUE;
         default: rdata = '0;
      endcase
   end

   assign epc_out = epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed, table-driven bench for cp0_unit: each vector drives one cycle,
// checks req before the edge, then reads back a register and req after it.
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        reset, we, bd_in, exl_clr;
   logic [4:0]  cp0_addr, exc_code_in;
   logic [31:0] wdata, vpc;
   logic [5:0]  hw_int;
   logic [31:0] rdata, epc_out;
   logic        req;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   cp0_unit dut (
      .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr), .wdata(wdata),
      .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in), .hw_int(hw_int),
      .exl_clr(exl_clr), .rdata(rdata), .epc_out(epc_out), .req(req)
   );

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] vpc;
      logic        bd;
      logic [4:0]  exc;
      logic [5:0]  hw;
      logic        clr;
      logic        req_pre;
      logic [4:0]  chk;
      logic [31:0] exp_rd;
      logic [31:0] exp_epc;
      logic        req_post;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vec [NVEC];

   function automatic vec_t mk(logic rst, logic w, logic [4:0] a, logic [31:0] wd,
                               logic [31:0] pc, logic bd, logic [4:0] exc,
                               logic [5:0] hw, logic clr, logic rq0, logic [4:0] chk,
                               logic [31:0] rd, logic [31:0] ep, logic rq1);
      vec_t v;
      v.rst = rst; v.we = w; v.addr = a; v.wdata = wd; v.vpc = pc; v.bd = bd;
      v.exc = exc; v.hw = hw; v.clr = clr; v.req_pre = rq0; v.chk = chk;
      v.exp_rd = rd; v.exp_epc = ep; v.req_post = rq1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      reset = 1'b0; we = 1'b0; cp0_addr = 5'd0; wdata = '0; vpc = '0;
      bd_in = 1'b0; exc_code_in = '0; hw_int = '0; exl_clr = 1'b0;
   endtask

   initial begin
      //            rst we addr wdata         vpc           bd exc  hw     clr rq0 chk  rdata         epc           rq1
      vec[0]  = mk(0, 1, 12, 32'h0000FC01, 32'h0,        0, 0,  6'h00, 0,  0,  12, 32'h0000FC01, 32'h0,        0);
      vec[1]  = mk(0, 0, 0,  32'h0,        32'h00003014, 0, 0,  6'h04, 0,  1,  13, 32'h00001000, 32'h00003014, 0);
      vec[2]  = mk(0, 0, 12, 32'h0,        32'h00003018, 0, 12, 6'h01, 0,  0,  12, 32'h0000FC03, 32'h00003014, 0);
      vec[3]  = mk(0, 0, 0,  32'h0,        32'h0,        0, 0,  6'h04, 1,  0,  12, 32'h0000FC01, 32'h00003014, 1);
      vec[4]  = mk(0, 0, 0,  32'h0,        32'h00003100, 0, 12, 6'h01, 0,  1,  13, 32'h00000400, 32'h00003100, 0);
      vec[5]  = mk(0, 0, 0,  32'h0,        32'h0,        0, 0,  6'h00, 1,  0,  12, 32'h0000FC01, 32'h00003100, 0);
      vec[6]  = mk(0, 0, 0,  32'h0,        32'h00003020, 1, 4,  6'h00, 0,  1,  13, 32'h80000010, 32'h0000301C, 0);
      vec[7]  = mk(0, 0, 0,  32'h0,        32'h0,        0, 0,  6'h00, 1,  0,  13, 32'h80000010, 32'h0000301C, 0);
      vec[8]  = mk(0, 1, 12, 32'h00000000, 32'h00003040, 0, 8,  6'h00, 0,  1,  12, 32'h0000FC03, 32'h00003040, 0);
      vec[9]  = mk(0, 1, 12, 32'h0000FC03, 32'h0,        0, 0,  6'h00, 1,  0,  12, 32'h0000FC01, 32'h00003040, 0);
      vec[10] = mk(0, 1, 14, 32'h00004183, 32'h0,        0, 0,  6'h00, 0,  0,  14, 32'h00004180, 32'h00004180, 0);
      vec[11] = mk(0, 1, 13, 32'hFFFFFFFF, 32'h0,        0, 0,  6'h00, 0,  0,  13, 32'h00000020, 32'h00004180, 0);
      vec[12] = mk(0, 1, 15, 32'h00000000, 32'h0,        0, 0,  6'h00, 0,  0,  15, 32'h20210007, 32'h00004180, 0);
      vec[13] = mk(0, 1, 0,  32'hFFFFFFFF, 32'h0,        0, 0,  6'h00, 0,  0,  16, 32'h00000000, 32'h00004180, 0);
      vec[14] = mk(0, 0, 0,  32'h0,        32'h00000002, 1, 4,  6'h00, 0,  1,  14, 32'hFFFFFFFE, 32'hFFFFFFFE, 0);
      vec[15] = mk(0, 0, 0,  32'h0,        32'h00000010, 0, 0,  6'h3F, 0,  0,  13, 32'h8000FC10, 32'hFFFFFFFE, 0);
      vec[16] = mk(0, 0, 0,  32'h0,        32'h0,        0, 0,  6'h00, 1,  0,  12, 32'h0000FC01, 32'hFFFFFFFE, 0);
      vec[17] = mk(0, 0, 0,  32'h0,        32'h00003014, 0, 4,  6'h00, 0,  1,  14, 32'h00003014, 32'h00003014, 0);
      vec[18] = mk(1, 1, 12, 32'hFFFFFFFF, 32'h0,        0, 0,  6'h04, 1,  0,  12, 32'h00000000, 32'h00000000, 0);
      vec[19] = mk(1, 0, 0,  32'h0,        32'h0,        0, 0,  6'h04, 0,  0,  13, 32'h00000000, 32'h00000000, 0);
      vec[20] = mk(0, 0, 0,  32'h0,        32'h0,        0, 0,  6'h00, 0,  0,  14, 32'h00000000, 32'h00000000, 0);

      // reset from power-up
      drive_idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cp0_addr = 5'd12; #1 check("reset_sr", rdata, 32'h0);
      cp0_addr = 5'd13; #1 check("reset_cause", rdata, 32'h0);
      cp0_addr = 5'd14; #1 check("reset_epc", rdata, 32'h0);
      check("reset_epc_out", epc_out, 32'h0);
      check("reset_req", {31'd0, req}, 32'h0);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         reset = vec[i].rst; we = vec[i].we; cp0_addr = vec[i].addr;
         wdata = vec[i].wdata; vpc = vec[i].vpc; bd_in = vec[i].bd;
         exc_code_in = vec[i].exc; hw_int = vec[i].hw; exl_clr = vec[i].clr;
         #1 check($sformatf("v%0d_req_pre", i), {31'd0, req}, {31'd0, vec[i].req_pre});
         @(posedge clk);
         #1;
         we = 1'b0; exl_clr = 1'b0; cp0_addr = vec[i].chk;
         #1;
         check($sformatf("v%0d_rdata", i), rdata, vec[i].exp_rd);
         check($sformatf("v%0d_epc_out", i), epc_out, vec[i].exp_epc);
         check($sformatf("v%0d_req_post", i), {31'd0, req}, {31'd0, vec[i].req_post});
      end

      // req follows its inputs within a cycle, no register in the path
      @(negedge clk);
      drive_idle();
      we = 1'b1; cp0_addr = 5'd12; wdata = 32'h0000FC01;
      @(posedge clk);
      #1 we = 1'b0;
      hw_int = 6'h04;      #1 check("comb_int_req", {31'd0, req}, 32'h1);
      hw_int = 6'h00;      #1 check("comb_idle", {31'd0, req}, 32'h0);
      exc_code_in = 5'd3;  #1 check("comb_exc_req", {31'd0, req}, 32'h1);
      exc_code_in = 5'd0;  #1 check("comb_idle2", {31'd0, req}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, limit 100000 expected completion");
      $fatal(1);
   end

endmodule
